radix_2_srt_div_iter: RTL and testbench
=======================================

Name: radix_2_srt_div_iter

Overview:
- Multi-cycle radix-2 SRT integer divider core, parametrised in operand width, signed/unsigned selectable per operation.
- Keeps the partial remainder in carry-save form and selects one quotient digit {-1,0,+1} per cycle from a 4-bit truncated estimate.
- Quotient assembled by on-the-fly conversion.
- Sits behind the integer execution unit's issue logic; valid/ready on both sides.

Parameters:
- WIDTH, 32, operand/result width; legal 8..64.
- REM_W, WIDTH+3, localparam; carry-save remainder width (sign + 2 guard bits).
- CNT_W, $clog2(WIDTH+1), localparam; iteration counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- start_valid_i  in  1  request valid
- start_ready_o  out  1  core idle, request accepted when both high
- signed_op_i  in  1  1 = signed, 0 = unsigned
- dividend_i  in  WIDTH  dividend A
- divisor_i  in  WIDTH  divisor D
- finish_valid_o  out  1  result valid
- finish_ready_i  in  1  downstream accepts result
- quotient_o  out  WIDTH  quotient, truncated toward zero
- remainder_o  out  WIDTH  remainder; sign follows the dividend
- div_by_zero_o  out  1  flag, valid with finish_valid_o

Behaviour:
- Reset values: start_ready_o=1, finish_valid_o=0, quotient_o=0, remainder_o=0, div_by_zero_o=0. FSM goes to IDLE.
- A reset asserted mid-operation aborts the operation; no result is produced.
- FSM states: IDLE, PRE, ITER, POST, DONE.
  - IDLE: start_ready_o=1. On handshake, latch the operands and go to PRE.
  - PRE (1 cycle):
    - Take magnitudes |A|, |D| and leading-zero counts lzc_a, lzc_d.
    - Form a_norm = |A|<<lzc_a and d_norm = |D|<<lzc_d.
    - Set w0 = a_norm/2 (sum = w0, carry = 0) and n = lzc_d - lzc_a + 1.
    - Special cases go straight to POST with no ITER:
      - D==0: Q = all ones, R = A, div_by_zero = 1.
      - Signed A = -2^(W-1) with D = -1: Q = A, R = 0.
      - |A|<|D|: Q = 0, R = A.
  - ITER (n cycles, n in 1..WIDTH):
    - Estimate y = top 4 bits of sum + top 4 bits of carry, 4-bit two's complement in halves.
    - Digit selection: y >= 0 gives q=+1; y == -1/2 gives q=0; y <= -1 gives q=-1.
    - Digit encoding is one-hot 2'b10=+1, 2'b00=0, 2'b01=-1.
    - Update w = 2w - q*d_norm through a 3:2 CSA. For q=+1 use inverted d_norm plus carry-in 1.
    - On-the-fly conversion:
      - q=+1: Q = Q<<1|1, QM = Q<<1.
      - q=0: Q = Q<<1, QM = QM<<1|1.
      - q=-1: Q = QM<<1|1, QM = QM<<1|0.
    - Counter decrements each cycle; leave ITER when it reaches 0.
  - POST (1 cycle):
    - Full-add sum+carry.
    - If the result is negative: Q = QM and w += d_norm.
    - R = w >> lzc_d (integer-aligned).
    - Apply signs: negate Q if sign(A)^sign(D); negate R if sign(A). Register the outputs.
  - DONE: finish_valid_o=1 with the outputs held stable until finish_ready_i; then return to IDLE.
- Latency from accept to finish_valid_o:
  - normal case: n + 3 cycles;
  - special cases: 3 cycles.
- start_ready_o is low outside IDLE. There is no back-to-back overlap: a new request is accepted in IDLE only.
- Invariant: |w| <= d_norm holds every iteration; the bench checks it in carry-save resolved form.

Optional Feature:
- Macro: RADIX_2_SRT_DIV_FLUSH_EN
- Defined:
  - Adds input port flush_i (1 bit).
  - flush_i high in any state forces IDLE on the next edge and clears finish_valid_o.
  - flush_i has priority over the start handshake in the same cycle.
- Undefined: no port; an operation always completes.

Decomposition:
- Package radix_2_srt_div_pkg:
  - FSM state enum;
  - quotient-digit encoding constants QDIG_POS=2'b10, QDIG_ZERO=2'b00, QDIG_NEG=2'b01.
- Sub-module radix_2_srt_div_lzc: parametrised leading-zero counter. Instantiated twice in PRE.
- The digit-selection logic is inline combinational, driven by the 4-bit estimate.

Test Plan:
- Unsigned 100/7 -> Q=14, R=2, div_by_zero=0. finish_valid_o rises n+3 cycles after accept.
- Signed -100/7 -> Q=-14 (0xFFFFFFF2), R=-2. Signed 100/-7 -> Q=-14, R=2.
- 5/0 -> Q=0xFFFFFFFF, R=5, div_by_zero=1, latency 3. Signed 0x80000000/0xFFFFFFFF -> Q=0x80000000, R=0.
- 3/10 -> Q=0, R=3, latency 3. 0xFFFFFFFF/1 unsigned -> Q=0xFFFFFFFF, R=0, n=32.
- Hold finish_ready_i=0 for 5 cycles -> outputs stable and start_ready_o=0 throughout. Assert rst during ITER -> next cycle start_ready_o=1 and finish_valid_o=0.
- Random 10^5 signed/unsigned pairs at WIDTH=8, 32 and 64 against a reference model. With RADIX_2_SRT_DIV_FLUSH_EN, flush during ITER -> idle next cycle and no result.

Source files
------------

// File: rtl/radix_2_srt_div_pkg.sv
// Shared types for the radix-2 SRT divider: FSM states and quotient-digit encoding.
package radix_2_srt_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_ITER,
        ST_POST,
        ST_DONE
    } state_t;

    localparam logic [1:0] QDIG_POS  = 2'b10;
    localparam logic [1:0] QDIG_ZERO = 2'b00;
    localparam logic [1:0] QDIG_NEG  = 2'b01;

endpackage

// File: rtl/radix_2_srt_div_lzc.sv
// Leading-zero counter; an all-zero input reports WIDTH.
module radix_2_srt_div_lzc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] value,
    output logic [CNT_W-1:0] count
);

    // Scan upward so the highest set bit is the last (winning) assignment.
    always_comb begin
        count = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (value[i]) begin
                count = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/radix_2_srt_div_iter.sv
// Multi-cycle radix-2 SRT divider with carry-save remainder and on-the-fly quotient conversion.
// Optional macro RADIX_2_SRT_DIV_FLUSH_EN adds flush_i, which aborts any operation back to IDLE.
module radix_2_srt_div_iter
    import radix_2_srt_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic             signed_op_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             finish_valid_o,
    input  logic             finish_ready_i,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
`ifdef RADIX_2_SRT_DIV_FLUSH_EN
    ,
    input  logic             flush_i
`endif
);

    localparam int REM_W = WIDTH + 3;
    localparam int CNT_W = $clog2(WIDTH + 1);
    // One extra fraction bit below REM_W keeps a_norm/2 exact when a_norm is odd.
    localparam int WF    = REM_W + 1;

    logic flush;
`ifdef RADIX_2_SRT_DIV_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, d_reg;
    logic             signed_reg;
    logic [WIDTH-1:0] d_norm_reg;
    logic [CNT_W-1:0] lzc_d_reg;
    logic [WF-1:0]    sum_reg, carry_reg;
    logic [WIDTH-1:0] q_reg, qm_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             special_reg, spec_dbz_reg;
    logic [WIDTH-1:0] spec_q_reg, spec_r_reg;
    logic             neg_q_reg, neg_r_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             dbz_reg;

    // Pre-processing: magnitudes, normalisation, special-case detection.
    logic             a_neg, d_neg;
    logic [WIDTH-1:0] a_mag, d_mag, a_norm, d_norm;
    logic [CNT_W-1:0] lzc_a, lzc_d, n_iter;
    logic             d_zero, ovf_case, small_case, special;

    assign a_neg      = signed_reg & a_reg[WIDTH-1];
    assign d_neg      = signed_reg & d_reg[WIDTH-1];
    assign a_mag      = a_neg ? -a_reg : a_reg;
    assign d_mag      = d_neg ? -d_reg : d_reg;
    assign a_norm     = a_mag << lzc_a;
    assign d_norm     = d_mag << lzc_d;
    assign n_iter     = lzc_d - lzc_a + CNT_W'(1);
    assign d_zero     = (d_reg == '0);
    assign ovf_case   = signed_reg && (a_reg == {1'b1, {(WIDTH-1){1'b0}}}) && (d_reg == '1);
    assign small_case = (a_mag < d_mag);
    assign special    = d_zero | ovf_case | small_case;

    radix_2_srt_div_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc_a (
        .value (a_mag),
        .count (lzc_a)
    );

    radix_2_srt_div_lzc #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_lzc_d (
        .value (d_mag),
        .count (lzc_d)
    );

    // Iteration: digit selection from the 4-bit estimate of 2w, CSA update, on-the-fly conversion.
    logic [WF-1:0]    d_ext, sum_sh, carry_sh, csa_z, sum_next, carry_next;
    logic [WF-2:0]    maj;
    logic [3:0]       est;
    logic [1:0]       qdig;
    logic             cin;
    logic [WIDTH-1:0] q_next, qm_next;

    assign d_ext    = {3'b000, d_norm_reg, 1'b0};
    assign sum_sh   = {sum_reg[WF-2:0], 1'b0};
    assign carry_sh = {carry_reg[WF-2:0], 1'b0};
    assign est      = sum_sh[WF-1 -: 4] + carry_sh[WF-1 -: 4];

    always_comb begin
        qdig = QDIG_NEG;
        if (!est[3]) begin
            qdig = QDIG_POS;
        end else if (est == 4'b1111) begin
            qdig = QDIG_ZERO;
        end
    end

    always_comb begin
        csa_z   = '0;
        cin     = 1'b0;
        q_next  = {q_reg[WIDTH-2:0], 1'b0};
        qm_next = {qm_reg[WIDTH-2:0], 1'b1};
        case (qdig)
            QDIG_POS: begin
                csa_z   = ~d_ext;
                cin     = 1'b1;
                q_next  = {q_reg[WIDTH-2:0], 1'b1};
                qm_next = {q_reg[WIDTH-2:0], 1'b0};
            end
            QDIG_NEG: begin
                csa_z   = d_ext;
                q_next  = {qm_reg[WIDTH-2:0], 1'b1};
                qm_next = {qm_reg[WIDTH-2:0], 1'b0};
            end
            default: ;
        endcase
    end

    assign sum_next   = sum_sh ^ carry_sh ^ csa_z;
    assign maj        = (sum_sh[WF-2:0] & carry_sh[WF-2:0])
                      | (sum_sh[WF-2:0] & csa_z[WF-2:0])
                      | (carry_sh[WF-2:0] & csa_z[WF-2:0]);
    assign carry_next = {maj, cin};

    // Post-processing: resolve, correct a negative remainder, denormalise, apply signs.
    logic [WF-1:0]    w_full;
    logic             w_neg;
    logic [WIDTH-1:0] r_aligned, r_mag, q_sel, q_fin, r_fin;

    assign w_full    = sum_reg + carry_reg;
    assign w_neg     = w_full[WF-1];
    assign r_aligned = w_full[WIDTH:1] + (w_neg ? d_norm_reg : '0);
    assign r_mag     = r_aligned >> lzc_d_reg;
    assign q_sel     = w_neg ? qm_reg : q_reg;
    assign q_fin     = neg_q_reg ? -q_sel : q_sel;
    assign r_fin     = neg_r_reg ? -r_mag : r_mag;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start_valid_i) state_next = ST_PRE;
            ST_PRE:  state_next = special ? ST_POST : ST_ITER;
            ST_ITER: if (cnt_reg == CNT_W'(1)) state_next = ST_POST;
            ST_POST: state_next = ST_DONE;
            ST_DONE: if (finish_ready_i) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        if (flush) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dbz_reg       <= 1'b0;
            special_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_valid_i) begin
                        a_reg      <= dividend_i;
                        d_reg      <= divisor_i;
                        signed_reg <= signed_op_i;
                    end
                end
                ST_PRE: begin
                    special_reg  <= special;
                    spec_dbz_reg <= d_zero;
                    spec_q_reg   <= d_zero ? '1 : (ovf_case ? a_reg : '0);
                    spec_r_reg   <= ovf_case ? '0 : a_reg;
                    neg_q_reg    <= a_neg ^ d_neg;
                    neg_r_reg    <= a_neg;
                    d_norm_reg   <= d_norm;
                    lzc_d_reg    <= lzc_d;
                    sum_reg      <= {4'b0000, a_norm};
                    carry_reg    <= '0;
                    q_reg        <= '0;
                    qm_reg       <= '0;
                    cnt_reg      <= n_iter;
                end
                ST_ITER: begin
                    sum_reg   <= sum_next;
                    carry_reg <= carry_next;
                    q_reg     <= q_next;
                    qm_reg    <= qm_next;
                    cnt_reg   <= cnt_reg - CNT_W'(1);
                end
                ST_POST: begin
                    if (special_reg) begin
                        quotient_reg  <= spec_q_reg;
                        remainder_reg <= spec_r_reg;
                        dbz_reg       <= spec_dbz_reg;
                    end else begin
                        quotient_reg  <= q_fin;
                        remainder_reg <= r_fin;
                        dbz_reg       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start_ready_o  = (state_reg == ST_IDLE);
    assign finish_valid_o = (state_reg == ST_DONE);
    assign quotient_o     = quotient_reg;
    assign remainder_o    = remainder_reg;
    assign div_by_zero_o  = dbz_reg;

endmodule

// File: tb/tb_radix_2_srt_div_iter.sv
// Directed and small randomised checks for radix_2_srt_div_iter at WIDTH=32.
module tb_radix_2_srt_div_iter;
    import radix_2_srt_div_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_valid = 1'b0;
    logic         start_ready;
    logic         signed_op = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         finish_valid;
    logic         finish_ready = 1'b1;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef RADIX_2_SRT_DIV_FLUSH_EN
    logic         flush = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    radix_2_srt_div_iter #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_valid_i  (start_valid),
        .start_ready_o  (start_ready),
        .signed_op_i    (signed_op),
        .dividend_i     (dividend),
        .divisor_i      (divisor),
        .finish_valid_o (finish_valid),
        .finish_ready_i (finish_ready),
        .quotient_o     (quotient),
        .remainder_o    (remainder),
        .div_by_zero_o  (div_by_zero)
`ifdef RADIX_2_SRT_DIV_FLUSH_EN
        ,
        .flush_i        (flush)
`endif
    );

    // Remainder bound |w| <= d_norm, checked on the resolved carry-save pair (half-LSB units).
    always @(negedge clk) begin
        if (!rst && dut.state_reg == ST_ITER) begin
            logic signed [W+3:0] w;
            logic signed [W+3:0] w_abs;
            logic signed [W+3:0] d2;
            w     = dut.sum_reg + dut.carry_reg;
            w_abs = (w < 0) ? -w : w;
            d2    = {3'b000, dut.d_norm_reg, 1'b0};
            checks++;
            if (w_abs > d2) begin
                errors++;
                $display("FAIL invariant: |w|=%0h exceeds 2*d_norm=%0h", w_abs, d2);
            end
        end
    end

    function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        z = 1'b0;
        if (b == '0) begin
            q = '1; r = a; z = 1'b1;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic int ref_lat(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] am, bm;
        int la, lb;
        if (b == '0) return 3;
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
        am = (s && a[W-1]) ? -a : a;
        bm = (s && b[W-1]) ? -b : b;
        if (am < bm) return 3;
        la = 0;
        while (la < W && !am[W-1-la]) la++;
        lb = 0;
        while (lb < W && !bm[W-1-lb]) lb++;
        return lb - la + 1 + 3;
    endfunction

    // Issues one request and waits (bounded) for the result; lat = -1 on timeout.
    task automatic run_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic z,
                           output int lat);
        @(negedge clk);
        signed_op    = s;
        dividend     = a;
        divisor      = b;
        start_valid  = 1'b1;
        finish_ready = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        lat = 1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (finish_valid) break;
            @(posedge clk);
            lat++;
        end
        q = quotient;
        r = remainder;
        z = div_by_zero;
        if (!finish_valid) lat = -1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || finish_valid !== 1'b0 || quotient !== '0 ||
            remainder !== '0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: ready=%b valid=%b q=%h r=%h dbz=%b required 1 0 0 0 0",
                     start_ready, finish_valid, quotient, remainder, div_by_zero);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] q, r;
        logic         z;
        int           lat;
        logic         s_t   [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] a_t   [9] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'hFFFF_FF9C, 32'd5,
                                    32'h8000_0000, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [W-1:0] b_t   [9] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd0,
                                    32'hFFFF_FFFF, 32'd10, 32'd1, 32'd3};
        logic [W-1:0] q_t   [9] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd14, 32'hFFFF_FFFF,
                                    32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hD555_5556};
        logic [W-1:0] r_t   [9] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFE, 32'd5,
                                    32'd0, 32'd3, 32'd0, 32'hFFFF_FFFE};
        logic         z_t   [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int           lat_t [9] = '{8, 8, 8, 8, 3, 3, 3, 35, 34};
        for (int i = 0; i < 9; i++) begin
            run_div(s_t[i], a_t[i], b_t[i], q, r, z, lat);
            checks++;
            if (q !== q_t[i] || r !== r_t[i] || z !== z_t[i] || lat != lat_t[i]) begin
                errors++;
                $display("FAIL directed[%0d]: q=%h r=%h dbz=%b lat=%0d required q=%h r=%h dbz=%b lat=%0d",
                         i, q, r, z, lat, q_t[i], r_t[i], z_t[i], lat_t[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        signed_op    = 1'b0;
        dividend     = 32'd100;
        divisor      = 32'd7;
        start_valid  = 1'b1;
        finish_ready = 1'b0;
        @(posedge clk);
        #1 start_valid = 1'b0;
        for (int k = 0; k < 100 && !finish_valid; k++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (finish_valid !== 1'b1 || start_ready !== 1'b0 ||
                quotient !== 32'd14 || remainder !== 32'd2) begin
                errors++;
                $display("FAIL backpressure[%0d]: valid=%b ready=%b q=%h r=%h required 1 0 0000000e 00000002",
                         c, finish_valid, start_ready, quotient, remainder);
            end
        end
        finish_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || finish_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release: ready=%b valid=%b required 1 0", start_ready, finish_valid);
        end
    endtask

    task automatic test_reset_mid_op();
        logic seen;
        @(negedge clk);
        signed_op   = 1'b0;
        dividend    = 32'hFFFF_FFFF;
        divisor     = 32'd1;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1 || finish_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_op: ready=%b valid=%b required 1 0", start_ready, finish_valid);
        end
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (finish_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result: finish_valid seen=%b required 0", seen);
        end
    endtask

`ifdef RADIX_2_SRT_DIV_FLUSH_EN
    task automatic test_flush();
        logic seen;
        @(negedge clk);
        signed_op   = 1'b0;
        dividend    = 32'hFFFF_FFFF;
        divisor     = 32'd1;
        start_valid = 1'b1;
        @(posedge clk);
        #1 start_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (start_ready !== 1'b1 || finish_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush: ready=%b valid=%b required 1 0", start_ready, finish_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (finish_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_result: finish_valid seen=%b required 0", seen);
        end
    endtask
`endif

    task automatic test_random();
        logic [W-1:0] a, b, q, r, eq, er;
        logic         s, z, ez;
        int           lat, elat;
        for (int i = 0; i < 150; i++) begin
            s = i[0];
            a = $urandom >> $urandom_range(0, 12);
            b = $urandom >> $urandom_range(0, 31);
            if (i % 17 == 0) b = '0;
            if (i % 23 == 0) a = 32'h8000_0000;
            ref_div(s, a, b, eq, er, ez);
            elat = ref_lat(s, a, b);
            run_div(s, a, b, q, r, z, lat);
            checks++;
            if (q !== eq || r !== er || z !== ez || lat != elat) begin
                errors++;
                $display("FAIL random[%0d] s=%b %h/%h: q=%h r=%h dbz=%b lat=%0d required q=%h r=%h dbz=%b lat=%0d",
                         i, s, a, b, q, r, z, lat, eq, er, ez, elat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_op();
`ifdef RADIX_2_SRT_DIV_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
